// File: rtl/mdu_iterdiv.sv
// rtl/mdu_iterdiv.sv - iterative restoring divider for div/divu/rem/remu and W-type variants
//
// Purpose: one quotient bit per cycle restoring divider with sign handling,
// divide-by-zero and signed-overflow results matching the integer ISA rules.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   StallM             Memory stage stall; holds the DONE state
//   FlushE             Execute stage flush; suppresses a start or aborts BUSY
//   IntDivE            divide/remainder instruction present in Execute
//   DivSignedE         signed operation
//   W64E               W-type (32-bit) operation, only meaningful when XLEN=64
//   ForwardedSrcAE     dividend
//   ForwardedSrcBE     divisor
//   DivBusyE           stall request to Execute (start cycle and all BUSY cycles)
//   QuotM, RemM        registered quotient and remainder
module mdu_iterdiv #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallM,
  input  logic            FlushE,
  input  logic            IntDivE,
  input  logic            DivSignedE,
  input  logic            W64E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            DivBusyE,
  output logic [XLEN-1:0] QuotM,
  output logic [XLEN-1:0] RemM
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  state_t state_next;

  logic            w64;
  logic            start;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] div_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   last_q;
  logic            sign_diff_q;
  logic            rem_neg_q;
  logic            div_zero_q;

  logic [XLEN:0]   rem_sh;
  logic            no_borrow;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quot_step;
  logic            cnt_last;
  logic            quot_neg;

  assign w64 = (XLEN == 64) && W64E;

  // W-type operations divide the low words, extended to the full width.
  always_comb begin
    a_ext = ForwardedSrcAE;
    b_ext = ForwardedSrcBE;
    if (w64) begin
      if (DivSignedE) begin
        a_ext = XLEN'($signed(ForwardedSrcAE[31:0]));
        b_ext = XLEN'($signed(ForwardedSrcBE[31:0]));
      end else begin
        a_ext = XLEN'(ForwardedSrcAE[31:0]);
        b_ext = XLEN'(ForwardedSrcBE[31:0]);
      end
    end
  end

  assign a_neg = DivSignedE && a_ext[XLEN-1];
  assign b_neg = DivSignedE && b_ext[XLEN-1];
  // The most-negative value maps to itself, which is also its unsigned magnitude.
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  assign start = (state == IDLE) && IntDivE && !FlushE;

  // One restoring step: the shifted partial remainder is one bit wider than
  // the divisor, but after a successful subtract it always fits XLEN bits.
  assign rem_sh    = {rem_q, quot_q[XLEN-1]};
  assign no_borrow = (rem_sh >= {1'b0, div_q});
  assign rem_step  = no_borrow ? (rem_sh[XLEN-1:0] - div_q) : rem_sh[XLEN-1:0];
  assign quot_step = {quot_q[XLEN-2:0], no_borrow};
  assign cnt_last  = (cnt == last_q);

  // A zero divisor yields all-ones, which must never be negated.
  assign quot_neg = sign_diff_q && !div_zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    DivBusyE   = 1'b0;
    case (state)
      IDLE: begin
        DivBusyE = IntDivE;
        if (IntDivE && !FlushE) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        DivBusyE = 1'b1;
        if (FlushE) begin
          state_next = IDLE;
        end else if (cnt_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!StallM) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q       <= '0;
      quot_q      <= '0;
      div_q       <= '0;
      cnt         <= '0;
      last_q      <= '0;
      sign_diff_q <= 1'b0;
      rem_neg_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      QuotM       <= '0;
      RemM        <= '0;
    end else if (start) begin
      rem_q       <= '0;
      // W-type dividends are parked in the upper half so 32 steps consume them.
      quot_q      <= w64 ? (a_mag << (XLEN / 2)) : a_mag;
      div_q       <= b_mag;
      cnt         <= '0;
      last_q      <= w64 ? CW'(31) : CW'(XLEN - 1);
      sign_diff_q <= a_neg ^ b_neg;
      rem_neg_q   <= a_neg;
      div_zero_q  <= (b_ext == '0);
    end else if ((state == BUSY) && !FlushE) begin
      rem_q  <= rem_step;
      quot_q <= quot_step;
      cnt    <= cnt + 1'b1;
      if (cnt_last) begin
        QuotM <= quot_neg ? -quot_step : quot_step;
        RemM  <= rem_neg_q ? -rem_step : rem_step;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterdiv.sv
// tb/tb_mdu_iterdiv.sv - self-checking bench for mdu_iterdiv
module tb_mdu_iterdiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallM;
  logic        FlushE;
  logic        IntDivE;
  logic        DivSignedE;
  logic        W64E;
  logic [63:0] ForwardedSrcAE;
  logic [63:0] ForwardedSrcBE;
  logic        DivBusyE;
  logic [63:0] QuotM;
  logic [63:0] RemM;

  int n_total = 0;
  int n_pass  = 0;

  mdu_iterdiv #(.XLEN(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .StallM         (StallM),
    .FlushE         (FlushE),
    .IntDivE        (IntDivE),
    .DivSignedE     (DivSignedE),
    .W64E           (W64E),
    .ForwardedSrcAE (ForwardedSrcAE),
    .ForwardedSrcBE (ForwardedSrcBE),
    .DivBusyE       (DivBusyE),
    .QuotM          (QuotM),
    .RemM           (RemM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Launches a division and counts DivBusyE-high cycles; returns in DONE at negedge+1.
  task automatic do_div(input logic s, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic stall, output int busy_cycles);
    @(negedge clk);
    StallM = stall; DivSignedE = s; W64E = w;
    ForwardedSrcAE = a; ForwardedSrcBE = b; IntDivE = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!DivBusyE) break;
      busy_cycles++;
      @(posedge clk);
      #1 IntDivE = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic go_busy_cycles(input int n);
    @(negedge clk);
    DivSignedE = 1'b1; W64E = 1'b0;
    ForwardedSrcAE = 64'd100; ForwardedSrcBE = 64'd7; IntDivE = 1'b1;
    @(posedge clk);
    #1 IntDivE = 1'b0;
    for (int k = 1; k < n; k++) @(posedge clk);
  endtask

  initial begin
    int cyc;
    logic [63:0] prev_q;
    logic [63:0] prev_r;

    vecs[0]  = '{1'b1, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65};
    vecs[1]  = '{1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 65};
    vecs[2]  = '{1'b0, 1'b0, 64'd7, 64'd2, 64'd3, 64'd1, 65};
    vecs[3]  = '{1'b1, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'd5, 65};
    vecs[4]  = '{1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'd5, 65};
    vecs[5]  = '{1'b1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'd0, 65};
    vecs[6]  = '{1'b1, 1'b1, 64'h00000001FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 33};
    vecs[7]  = '{1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h10, 64'h0FFFFFFFFFFFFFFF, 64'hF, 65};
    vecs[8]  = '{1'b1, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFD, 64'd1, 65};
    vecs[9]  = '{1'b0, 1'b1, 64'hFFFFFFFF80000000, 64'd3, 64'h2AAAAAAA, 64'd2, 33};
    vecs[10] = '{1'b1, 1'b0, 64'hFFFFFFFFFFFFFF9C, 64'hFFFFFFFFFFFFFFF9, 64'd14, 64'hFFFFFFFFFFFFFFFE, 65};

    reset = 1'b1; StallM = 1'b0; FlushE = 1'b0; IntDivE = 1'b0;
    DivSignedE = 1'b0; W64E = 1'b0; ForwardedSrcAE = '0; ForwardedSrcBE = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_quot", QuotM, 64'd0);
    check("reset_rem", RemM, 64'd0);
    check("reset_busy", {63'd0, DivBusyE}, 64'd0);

    for (int i = 0; i < 11; i++) begin
      do_div(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].b, 1'b0, cyc);
      check($sformatf("v%0d_quot", i), QuotM, vecs[i].q);
      check($sformatf("v%0d_rem", i), RemM, vecs[i].r);
      check($sformatf("v%0d_busy_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
    end
    prev_q = vecs[10].q;
    prev_r = vecs[10].r;

    // Flush at BUSY cycle 10 aborts and leaves results alone.
    go_busy_cycles(10);
    @(negedge clk);
    FlushE = 1'b1;
    @(posedge clk);
    #1 FlushE = 1'b0;
    @(negedge clk);
    check("flush_busy_next", {63'd0, DivBusyE}, 64'd0);
    check("flush_quot_kept", QuotM, prev_q);
    check("flush_rem_kept", RemM, prev_r);

    // Flush in the start cycle suppresses the start.
    @(negedge clk);
    DivSignedE = 1'b0; ForwardedSrcAE = 64'd9; ForwardedSrcBE = 64'd4;
    IntDivE = 1'b1; FlushE = 1'b1;
    @(posedge clk);
    #1 IntDivE = 1'b0; FlushE = 1'b0;
    @(negedge clk);
    check("start_flush_busy", {63'd0, DivBusyE}, 64'd0);
    repeat (3) @(negedge clk);
    check("start_flush_quot", QuotM, prev_q);

    // Reset at BUSY cycle 20.
    go_busy_cycles(20);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_quot", QuotM, 64'd0);
    check("midreset_rem", RemM, 64'd0);
    check("midreset_busy", {63'd0, DivBusyE}, 64'd0);

    // StallM held from the start: no effect in BUSY, holds DONE, no restart.
    do_div(1'b1, 1'b0, 64'd100, 64'd7, 1'b1, cyc);
    check("stall_busy_cycles", 64'(cyc), 64'd65);
    check("stall_quot", QuotM, 64'd14);
    check("stall_rem", RemM, 64'd2);
    IntDivE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("done_hold%0d_busy", k), {63'd0, DivBusyE}, 64'd0);
      check($sformatf("done_hold%0d_quot", k), QuotM, 64'd14);
      check($sformatf("done_hold%0d_rem", k), RemM, 64'd2);
    end
    IntDivE = 1'b0;
    StallM  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("done_exit_busy", {63'd0, DivBusyE}, 64'd0);
    check("done_exit_quot", QuotM, 64'd14);

    do_div(1'b0, 1'b0, 64'd7, 64'd2, 1'b0, cyc);
    check("after_done_busy_cycles", 64'(cyc), 64'd65);
    check("after_done_quot", QuotM, 64'd3);
    check("after_done_rem", RemM, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_iterdiv.md
MDU_ITERDIV -- requirements
Module: mduiterdiv

Interface
REQ-001 SHALL have parameter: XLEN, default 64, datapath width (32 or 64).
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- StallM  in  1  Memory stage stalled
- FlushE  in  1  Execute stage flushed
- IntDivE  in  1  div/divu/rem/remu instruction in Execute
- DivSignedE  in  1  signed operation
- W64E  in  1  W-type operation (ignored when XLEN=32)
- ForwardedSrcAE  in  XLEN  dividend
- ForwardedSrcBE  in  XLEN  divisor
- DivBusyE  out  1  stall request to the Execute stage
- QuotM  out  XLEN  quotient, registered
- RemM  out  XLEN  remainder, registered

Function
REQ-003 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-004 Start: SHALL start when state=IDLE, IntDivE=1 and FlushE=0. On the start edge it SHALL:
- latch the operand magnitudes
- latch the result sign flags and the divide-by-zero flag
- clear the iteration counter
- go to BUSY.
REQ-005 SHALL drive DivBusyE combinationally high in the start cycle and in every BUSY cycle, and low in IDLE and DONE.
REQ-006 BUSY SHALL perform one restoring-division step per cycle: shift {rem,quot} left one bit, trial-subtract the divisor, set the quotient bit if no borrow, otherwise restore.
REQ-007 SHALL run N iterations, where N=32 when W64E=1 and XLEN=64, and N=XLEN otherwise. DivBusyE SHALL therefore stay high for exactly N+1 cycles.
REQ-008 On the edge ending the Nth BUSY cycle, SHALL write the sign-corrected QuotM/RemM and go to DONE.
REQ-009 Operand preparation:
- W64E=1: use the low 32 bits of each operand, sign-extended if DivSignedE=1, zero-extended otherwise.
- Signed operation: use absolute values.
REQ-010 Sign correction:
- Quotient: negated when the operand signs differ and the divisor is nonzero.
- Remainder: takes the dividend's sign.
- Unsigned operation: no correction.
REQ-011 Divisor=0 SHALL give QuotM=all ones and RemM=dividend (extended per REQ-009), for both signed and unsigned operations.
REQ-012 Signed overflow (most-negative / -1) SHALL give QuotM=most-negative value and RemM=0.
REQ-013 W64 results SHALL be correct in bits [31:0]. Upper bits are the XLEN-wide result of the extended operands; downstream sign-extends.
REQ-014 DONE SHALL return to IDLE on the first edge with StallM=0. IntDivE seen while in DONE SHALL NOT start a new division.
REQ-015 QuotM/RemM SHALL hold their values in DONE and IDLE until the next completion.
REQ-016 FlushE=1 in BUSY SHALL abort to IDLE on that edge. QuotM/RemM SHALL be left unchanged, and DivBusyE SHALL be low the following cycle.
REQ-017 FlushE=1 in the start cycle SHALL suppress the start. The start-cycle DivBusyE pulse is permitted.
REQ-018 StallM SHALL have no effect in IDLE or BUSY.

Reset
REQ-019 reset=1 at a clock edge SHALL force IDLE, clear the counter and internal registers, and set QuotM=0 and RemM=0, from any state including mid-BUSY.
REQ-020 With reset low after a reset, DivBusyE SHALL be 0 unless IntDivE=1.

Verification
REQ-021 XLEN=64, signed, 100/7 -> QuotM=14, RemM=2; DivBusyE high 65 cycles; DONE then IDLE when StallM=0.
REQ-022 Signed -7/2 -> QuotM=0xFFFFFFFFFFFFFFFD, RemM=0xFFFFFFFFFFFFFFFF. Unsigned 7/2 -> QuotM=3, RemM=1.
REQ-023 Divide by zero: signed 5/0 and unsigned 5/0 -> QuotM=0xFFFFFFFFFFFFFFFF, RemM=5.
REQ-024 Overflow: signed 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> QuotM=0x8000000000000000, RemM=0.
REQ-025 W-type: divw with A=0x00000001FFFFFFF9, B=2 -> QuotM[31:0]=0xFFFFFFFD, RemM[31:0]=0xFFFFFFFF; DivBusyE high 33 cycles.
REQ-026 Abort and hold:
- FlushE pulse at BUSY cycle 10 -> IDLE, DivBusyE=0 next cycle, previous QuotM retained.
- reset at BUSY cycle 20 -> IDLE, QuotM=RemM=0.
- StallM held 3 cycles in DONE -> stays DONE, no restart, outputs stable.
